// File: rtl/hilo_div_ctrl_pkg.sv
// Shared constants for the execute-stage HI/LO divide controller:
// default datapath width, op encodings and FSM state encodings.
package hilo_div_ctrl_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef logic [2:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NONE = 3'd0;
    localparam op_t OP_DIV  = 3'd1;
    localparam op_t OP_DIVU = 3'd2;
    localparam op_t OP_MTHI = 3'd3;
    localparam op_t OP_MTLO = 3'd4;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/hilo_div_ctrl.sv
// Execute-stage front end for the unsigned stream_divider: converts signed
// operands to magnitudes, sequences the divider handshake and owns HI/LO.
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_reminder
);

    function automatic logic [WIDTH-1:0] neg_val(input logic [WIDTH-1:0] v);
        return '0 - v;
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg_val(v) : v;
    endfunction

    state_t           state_q,    state_d;
    logic             busy_q,     busy_d;
    logic             start_q,    start_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q,  divisor_d;
    logic [WIDTH-1:0] raw_q_q,    raw_q_d;
    logic [WIDTH-1:0] raw_r_q,    raw_r_d;
    logic             q_neg_q,    q_neg_d;
    logic             r_neg_q,    r_neg_d;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        start_d    = start_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        raw_q_d    = raw_q_q;
        raw_r_d    = raw_r_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_DIV, OP_DIVU: begin
                            busy_d = 1'b1;
                            if (rt_val == '0) begin
                                // Divide by zero bypasses the divider: preload the
                                // raw result so FIX writes hi=rs, lo=all-ones unchanged.
                                raw_q_d = '1;
                                raw_r_d = rs_val;
                                q_neg_d = 1'b0;
                                r_neg_d = 1'b0;
                                state_d = ST_FIX;
                            end else begin
                                dividend_d = (op == OP_DIV) ? abs_val(rs_val) : rs_val;
                                divisor_d  = (op == OP_DIV) ? abs_val(rt_val) : rt_val;
                                q_neg_d    = (op == OP_DIV) & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                                r_neg_d    = (op == OP_DIV) & rs_val[WIDTH-1];
                                start_d    = 1'b1;
                                state_d    = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (div_done) begin
                    raw_q_d = div_quotient;
                    raw_r_d = div_reminder;
                    start_d = 1'b0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                lo_d    = q_neg_q ? neg_val(raw_q_q) : raw_q_q;
                hi_d    = r_neg_q ? neg_val(raw_r_q) : raw_r_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            raw_q_q    <= '0;
            raw_r_q    <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            start_q    <= start_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            raw_q_q    <= raw_q_d;
            raw_r_q    <= raw_r_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
        end
    end

    assign busy         = busy_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_start    = start_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: directed vector table, hand-written
// corner sequences and randomized ops against an arithmetic reference model.
module tb_hilo_div_ctrl;
    import hilo_div_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, div_start, div_done;
    logic [31:0] hi, lo, div_dividend, div_divisor, div_quotient, div_reminder;

    int checks = 0;
    int errors = 0;

    // Divider model: raises done once start has been seen on dn+1 falling edges,
    // holds it until start drops. force_done injects stray pulses.
    int          dn = 0;
    bit          auto_en = 1'b1;
    logic        auto_done = 1'b0;
    logic        force_done = 1'b0;
    logic [31:0] dq = '0, dr = '0;

    assign div_done     = auto_done | force_done;
    assign div_quotient = dq;
    assign div_reminder = dr;

    hilo_div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_reminder(div_reminder)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : divider_model
        int cnt;
        if (!auto_en || !div_start) begin
            cnt = 0;
            auto_done = 1'b0;
        end else if (!auto_done) begin
            cnt++;
            if (cnt == dn + 1) begin
                auto_done = 1'b1;
                dq = (div_divisor != 0) ? div_dividend / div_divisor : '1;
                dr = (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one op for one edge, then follow busy until it drops.
    task automatic do_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                         input int n, output int bcnt, output bit started,
                         output logic [31:0] dvd, output logic [31:0] dvs, output bit order_ok);
        bit seen_done;
        dn = n;
        op_valid = 1'b1; op = o; rs_val = rs; rt_val = rt;
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NONE;
        bcnt = 0; started = 0; dvd = '0; dvs = '0; order_ok = 1; seen_done = 0;
        while (busy && bcnt < 400) begin
            bcnt++;
            if (div_start && !started) begin
                started = 1; dvd = div_dividend; dvs = div_divisor;
            end
            if (div_done && !seen_done) begin
                seen_done = 1;
                if (div_start) order_ok = 0;
            end
            if (started && !div_start && !seen_done) order_ok = 0;
            @(posedge clk); #1;
        end
        if (started && !seen_done) order_ok = 0;
        if (bcnt >= 400) chk("busy_timeout", 32'(bcnt), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt;
        int          n, exp_busy;
        logic [31:0] exp_hi, exp_lo, exp_dvd, exp_dvs;
    } vec_t;

    function automatic logic [31:0] pick(input bit divisor);
        case ($urandom_range(0, 7))
            0:       return divisor ? 32'd0 : 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 40));
            3:       return 32'd0 - 32'($urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t vecs[11];
        int bcnt;
        bit started, order_ok;
        logic [31:0] dvd, dvs, mh, ml;

        vecs[0]  = '{OP_DIVU, 32'd30,         32'd7,          33, 35, 32'd2,         32'd4,         32'd30,        32'd7};
        vecs[1]  = '{OP_DIV,  32'hFFFF_FFE2,  32'd7,           4,  6, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'd30,        32'd7};
        vecs[2]  = '{OP_DIV,  32'd30,         32'hFFFF_FFF9,   2,  4, 32'd2,         32'hFFFF_FFFC, 32'd30,        32'd7};
        vecs[3]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,   1,  3, 32'd0,         32'h8000_0000, 32'h8000_0000, 32'd1};
        vecs[4]  = '{OP_DIVU, 32'h1234,       32'd0,           5,  1, 32'h1234,      32'hFFFF_FFFF, 32'd0,         32'd0};
        vecs[5]  = '{OP_MTHI, 32'hDEAD_BEEF,  32'd9,           0,  0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0,         32'd0};
        vecs[6]  = '{OP_MTLO, 32'h55,         32'd9,           0,  0, 32'hDEAD_BEEF, 32'h55,        32'd0,         32'd0};
        vecs[7]  = '{3'd7,    32'h1111,       32'd3,           0,  0, 32'hDEAD_BEEF, 32'h55,        32'd0,         32'd0};
        vecs[8]  = '{OP_NONE, 32'h2222,       32'd3,           0,  0, 32'hDEAD_BEEF, 32'h55,        32'd0,         32'd0};
        vecs[9]  = '{OP_DIV,  32'd7,          32'd0,           3,  1, 32'd7,         32'hFFFF_FFFF, 32'd0,         32'd0};
        vecs[10] = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,   0,  2, 32'hFFFF_FFFF, 32'd3,         32'd7,         32'd2};

        reset = 1'b0; op_valid = 1'b0; op = OP_NONE; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dividend", div_dividend, 32'd0);
        chk("rst_divisor", div_divisor, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            bit exp_start;
            exp_start = (vecs[i].op == OP_DIV || vecs[i].op == OP_DIVU) && vecs[i].rt != 0;
            do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].n, bcnt, started, dvd, dvs, order_ok);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_started", i), 32'(started), 32'(exp_start));
            chk($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            if (exp_start) begin
                chk($sformatf("v%0d_dividend", i), dvd, vecs[i].exp_dvd);
                chk($sformatf("v%0d_divisor", i), dvs, vecs[i].exp_dvs);
                chk($sformatf("v%0d_start_fall", i), 32'(order_ok), 32'd1);
            end
        end

        // MTLO held during a running DIVU must not be taken.
        begin
            int cyc;
            dn = 10;
            op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd30; rt_val = 32'd7;
            @(posedge clk); #1;
            op = OP_MTLO; rs_val = 32'h55;
            cyc = 0;
            while (busy && cyc < 400) begin
                cyc++;
                @(posedge clk); #1;
            end
            op_valid = 1'b0; op = OP_NONE;
            chk("mtlo_busy_cycles", 32'(cyc), 32'd12);
            chk("mtlo_lo", lo, 32'd4);
            chk("mtlo_hi", hi, 32'd2);
            @(posedge clk); #1;
            chk("mtlo_lo_after", lo, 32'd4);
        end

        // Reset mid-RUN abandons the divide; stray done pulses are ignored.
        dn = 20;
        op_valid = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NONE;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_start_before_rst", 32'(div_start), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_start", 32'(div_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        auto_en = 1'b0;
        dq = 32'hAAAA_0001; dr = 32'h5555_0002;
        force_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        force_done = 1'b0;
        @(posedge clk); #1;
        chk("stray_done_hi", hi, 32'd0);
        chk("stray_done_lo", lo, 32'd0);
        chk("stray_done_busy", 32'(busy), 32'd0);
        chk("stray_done_start", 32'(div_start), 32'd0);
        auto_en = 1'b1;
        do_op(OP_DIVU, 32'd100, 32'd9, 3, bcnt, started, dvd, dvs, order_ok);
        chk("post_rst_busy_cycles", 32'(bcnt), 32'd5);
        chk("post_rst_lo", lo, 32'd11);
        chk("post_rst_hi", hi, 32'd1);

        // Randomized ops against an arithmetic model of HI/LO.
        mh = 32'd1; ml = 32'd11;
        for (int k = 0; k < 150; k++) begin
            logic [2:0]  o;
            logic [31:0] rs, rt;
            int n, exp_busy;
            int unsigned sel;
            sel = $urandom_range(0, 9);
            o = (sel < 3) ? OP_DIV : (sel < 6) ? OP_DIVU : (sel == 6) ? OP_MTHI :
                (sel == 7) ? OP_MTLO : (sel == 8) ? OP_NONE : 3'($urandom_range(5, 7));
            rs = pick(1'b0);
            rt = pick(1'b1);
            n  = $urandom_range(0, 6);
            exp_busy = 0;
            case (o)
                OP_MTHI: mh = rs;
                OP_MTLO: ml = rs;
                OP_DIV, OP_DIVU: begin
                    if (rt == 0) begin
                        mh = rs; ml = '1; exp_busy = 1;
                    end else begin
                        exp_busy = n + 2;
                        if (o == OP_DIVU) begin
                            ml = rs / rt; mh = rs % rt;
                        end else begin
                            longint a, b, q, r;
                            a = longint'($signed(rs));
                            b = longint'($signed(rt));
                            q = a / b;
                            r = a % b;
                            ml = q[31:0]; mh = r[31:0];
                        end
                    end
                end
                default: ;
            endcase
            do_op(o, rs, rt, n, bcnt, started, dvd, dvs, order_ok);
            chk($sformatf("r%0d_busy_cycles op=%0d", k, o), 32'(bcnt), 32'(exp_busy));
            chk($sformatf("r%0d_hi op=%0d rs=%h rt=%h", k, o, rs, rt), hi, mh);
            chk($sformatf("r%0d_lo op=%0d rs=%h rt=%h", k, o, rs, rt), lo, ml);
            if (exp_busy > 1) chk($sformatf("r%0d_start_fall", k), 32'(order_ok), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
